// File: rtl/paddle_sampler.sv
// Paddle front end: synchronise, optionally filter, and timestamp the first paddle rise per frame against vpos.
// Optional macro PADDLE_FILTER_EN enables the FILTER_LEN consecutive-high acceptance filter.
module paddle_sampler #(
    parameter int unsigned     WIDTH      = 16,
    parameter logic [WIDTH-1:0] MISS_VALUE = '1,
    parameter int unsigned     FILTER_LEN = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_hpaddle,
    input  logic             i_vpaddle,
    input  logic             i_vsync,
    input  logic [WIDTH-1:0] i_vpos,
    output logic [WIDTH-1:0] o_paddle_x,
    output logic [WIDTH-1:0] o_paddle_y,
    output logic             o_hmiss,
    output logic             o_vmiss,
    output logic             o_frame_valid
);

    localparam int unsigned NCH   = 2;
    localparam int unsigned CNT_W = 4;

    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("paddle_sampler: FILTER_LEN must be in 1..15");
    end

    typedef enum logic {
        ARMED    = 1'b0,
        CAPTURED = 1'b1
    } state_t;

    // Channel 0 is horizontal, channel 1 is vertical.
    logic [NCH-1:0]   r_sync1;
    logic [NCH-1:0]   r_sync2;
    logic [NCH-1:0]   r_low_seen;
    logic             r_vld;
    logic             r_vsync;
    logic [NCH-1:0]   w_edge;
    logic             w_boundary;
    state_t           r_state [NCH];
    state_t           w_next  [NCH];
    logic [NCH-1:0]   w_cap_en;
    logic [NCH-1:0]   w_pub_miss;
    logic [WIDTH-1:0] r_cap   [NCH];
    logic [WIDTH-1:0] r_paddle_x;
    logic [WIDTH-1:0] r_paddle_y;
    logic             r_hmiss;
    logic             r_vmiss;
    logic             r_frame_valid;

    // A low must be observed after reset before any rise can count as an edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_low_seen <= '0;
            r_vld      <= 1'b0;
            r_vsync    <= 1'b0;
        end else begin
            r_sync1    <= {i_vpaddle, i_hpaddle};
            r_sync2    <= r_sync1;
            r_low_seen <= r_low_seen | ({NCH{r_vld}} & ~r_sync1);
            r_vld      <= 1'b1;
            r_vsync    <= i_vsync;
        end
    end

`ifdef PADDLE_FILTER_EN
    logic [CNT_W-1:0] r_cnt [NCH];

    // Saturating count of consecutive synchronised-high cycles.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int ch = 0; ch < NCH; ch++) r_cnt[ch] <= '0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (!r_sync2[ch]) begin
                    r_cnt[ch] <= '0;
                end else if (r_cnt[ch] != CNT_W'(FILTER_LEN)) begin
                    r_cnt[ch] <= r_cnt[ch] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_edge = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            w_edge[ch] = r_sync2[ch] & r_low_seen[ch] & (r_cnt[ch] == CNT_W'(FILTER_LEN - 1));
        end
    end
`else
    logic [NCH-1:0] r_prev;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_prev <= '0;
        else         r_prev <= r_sync2;
    end

    assign w_edge = r_sync2 & ~r_prev & r_low_seen;
`endif

    assign w_boundary = i_vsync & ~r_vsync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int ch = 0; ch < NCH; ch++) r_state[ch] <= ARMED;
        end else begin
            for (int ch = 0; ch < NCH; ch++) r_state[ch] <= w_next[ch];
        end
    end

    // An edge on the boundary cycle belongs to the new frame.
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            w_next[ch] = r_state[ch];
            if (w_boundary) begin
                w_next[ch] = w_edge[ch] ? CAPTURED : ARMED;
            end else if (r_state[ch] == ARMED && w_edge[ch]) begin
                w_next[ch] = CAPTURED;
            end
        end
    end

    always_comb begin
        w_cap_en   = '0;
        w_pub_miss = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            w_cap_en[ch]   = w_edge[ch] & (w_boundary | (r_state[ch] == ARMED));
            w_pub_miss[ch] = (r_state[ch] == ARMED);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int ch = 0; ch < NCH; ch++) r_cap[ch] <= '0;
            r_paddle_x    <= '0;
            r_paddle_y    <= '0;
            r_hmiss       <= 1'b0;
            r_vmiss       <= 1'b0;
            r_frame_valid <= 1'b0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (w_cap_en[ch]) r_cap[ch] <= i_vpos;
            end
            r_frame_valid <= w_boundary;
            if (w_boundary) begin
                r_paddle_x <= w_pub_miss[0] ? MISS_VALUE : r_cap[0];
                r_paddle_y <= w_pub_miss[1] ? MISS_VALUE : r_cap[1];
                r_hmiss    <= w_pub_miss[0];
                r_vmiss    <= w_pub_miss[1];
            end
        end
    end

    assign o_paddle_x    = r_paddle_x;
    assign o_paddle_y    = r_paddle_y;
    assign o_hmiss       = r_hmiss;
    assign o_vmiss       = r_vmiss;
    assign o_frame_valid = r_frame_valid;

endmodule

// File: tb/tb_paddle_sampler.sv
// Bench for paddle_sampler: frame-level reference model plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_paddle_sampler;

`ifdef PADDLE_FILTER_EN
    localparam int L = 4;
`else
    localparam int L = 1;
`endif
    localparam int LAT  = L - 1;
    localparam int HMAX = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hpaddle = 1'b0;
    logic        vpaddle = 1'b0;
    logic        vsync = 1'b0;
    logic [15:0] vpos = 16'd0;
    logic [15:0] paddle_x, paddle_y;
    logic        hmiss, vmiss, frame_valid;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    paddle_sampler #(.WIDTH(16), .FILTER_LEN(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_hpaddle(hpaddle), .i_vpaddle(vpaddle),
        .i_vsync(vsync), .i_vpos(vpos), .o_paddle_x(paddle_x), .o_paddle_y(paddle_y),
        .o_hmiss(hmiss), .o_vmiss(vmiss), .o_frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    // Reference model: sample history since reset release, first accepted rise per frame.
    bit          sh [HMAX];
    bit          sv [HMAX];
    bit          svs[HMAX];
    int          k;
    bit          h_have, v_have;
    logic [15:0] h_val, v_val;
    logic [15:0] e_x, e_y;
    bit          e_hm, e_vm, e_fv;

    function automatic bit rise_at(input bit ch, input int kk);
        int f;
        f = kk - 1 - L;
        if (f - 1 < 0) return 1'b0;
        if (ch ? sv[f-1] : sh[f-1]) return 1'b0;
        for (int j = 0; j < L; j++) begin
            if (!(ch ? sv[f+j] : sh[f+j])) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k = 0; h_have = 0; v_have = 0; h_val = 0; v_val = 0;
            e_x = 0; e_y = 0; e_hm = 0; e_vm = 0; e_fv = 0;
        end else if (k < HMAX) begin
            bit eh, ev, bnd;
            sh[k] = hpaddle; sv[k] = vpaddle; svs[k] = vsync;
            eh  = rise_at(1'b0, k);
            ev  = rise_at(1'b1, k);
            bnd = vsync && (k == 0 || !svs[k-1]);
            e_fv = bnd;
            if (bnd) begin
                e_x  = h_have ? h_val : 16'hFFFF;
                e_y  = v_have ? v_val : 16'hFFFF;
                e_hm = !h_have;
                e_vm = !v_have;
                h_have = 0;
                v_have = 0;
            end
            if (eh && !h_have) begin h_have = 1; h_val = vpos; end
            if (ev && !v_have) begin v_have = 1; v_val = vpos; end
            k = k + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks = checks + 1;
            if (paddle_x !== e_x || paddle_y !== e_y || hmiss !== e_hm ||
                vmiss !== e_vm || frame_valid !== e_fv) begin
                failures = failures + 1;
                $display("FAIL model t=%0t: got x=%0d y=%0d hm=%0b vm=%0b fv=%0b expected x=%0d y=%0d hm=%0b vm=%0b fv=%0b",
                         $time, paddle_x, paddle_y, hmiss, vmiss, frame_valid,
                         e_x, e_y, e_hm, e_vm, e_fv);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        vpos = vpos + 16'd1;
    endtask

    task automatic go_to(input int v);
        int g = 0;
        while (vpos != 16'(v) && g < 5000) begin
            tick();
            g++;
        end
        if (g >= 5000) chk("go_to_timeout", 32'(vpos), 32'(v));
    endtask

    task automatic set_reset(input logic val);
        @(negedge clk);
        #2 rst = val;
    endtask

    // Pulse vsync for two cycles and check the publish and the hold after it.
    task automatic publish(input string nm, input int ex, input int ey, input bit ehm, input bit evm);
        vsync = 1'b1;
        tick();
        chk({nm, "_fv"}, 32'(frame_valid), 32'd1);
        chk({nm, "_x"}, 32'(paddle_x), 32'(ex));
        chk({nm, "_y"}, 32'(paddle_y), 32'(ey));
        chk({nm, "_hmiss"}, 32'(hmiss), 32'(ehm));
        chk({nm, "_vmiss"}, 32'(vmiss), 32'(evm));
        tick();
        chk({nm, "_fv_drop"}, 32'(frame_valid), 32'd0);
        chk({nm, "_x_hold"}, 32'(paddle_x), 32'(ex));
        vsync = 1'b0;
        tick();
    endtask

    initial begin
        #1 rst = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_x", 32'(paddle_x), 0);
        chk("reset_fv", 32'(frame_valid), 0);
        set_reset(1'b0);
        vpos = 16'd0;

        // Normal capture
        go_to(100); hpaddle = 1'b1;
        go_to(200); vpaddle = 1'b1;
        go_to(210); hpaddle = 1'b0; vpaddle = 1'b0;
        go_to(220);
        publish("normal", 102 + LAT, 202 + LAT, 1'b0, 1'b0);

        // Miss on the vertical channel
        go_to(250); hpaddle = 1'b1;
        go_to(260); hpaddle = 1'b0;
        go_to(270);
        publish("miss", 252 + LAT, 16'hFFFF, 1'b0, 1'b1);

        // Repeated pulses within one frame
        vpos = 16'd40;
        go_to(50); hpaddle = 1'b1;
        go_to(56); hpaddle = 1'b0;
        go_to(80); hpaddle = 1'b1;
        go_to(86); hpaddle = 1'b0;
        go_to(90);
        publish("multi", 52 + LAT, 16'hFFFF, 1'b0, 1'b1);

        // Edge detected on the same cycle as the vsync rise
        vpos = 16'd280;
        go_to(298 - LAT); hpaddle = 1'b1;
        go_to(300);
        publish("simul_cur", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        go_to(310); hpaddle = 1'b0;
        go_to(320);
        publish("simul_next", 300, 16'hFFFF, 1'b0, 1'b1);

        // Reset in the middle of a frame discards the capture
        vpos = 16'd30;
        go_to(40); hpaddle = 1'b1;
        go_to(46); hpaddle = 1'b0;
        go_to(50);
        set_reset(1'b1);
        tick();
        chk("midrst_x", 32'(paddle_x), 0);
        chk("midrst_y", 32'(paddle_y), 0);
        chk("midrst_hmiss", 32'(hmiss), 0);
        chk("midrst_vmiss", 32'(vmiss), 0);
        set_reset(1'b0);
        go_to(60);
        publish("midrst_pub", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);

        // Short glitch then a sustained rise: the filter rejects the glitch
        vpos = 16'd0;
        go_to(10); hpaddle = 1'b1;
        go_to(12); hpaddle = 1'b0;
        go_to(60); hpaddle = 1'b1;
        go_to(70); hpaddle = 1'b0;
        go_to(80);
        publish("filter", (L > 1) ? 65 : 12, 16'hFFFF, 1'b0, 1'b1);

        // Vertical paddle already high at reset release
        set_reset(1'b1);
        vpaddle = 1'b1;
        tick(); tick();
        set_reset(1'b0);
        vpos = 16'd500;
        go_to(520);
        publish("high_at_rel", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        vpaddle = 1'b0;
        go_to(530); vpaddle = 1'b1;
        go_to(540); vpaddle = 1'b0;
        go_to(550);
        publish("after_low", 16'hFFFF, 532 + LAT, 1'b1, 1'b0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/paddle_sampler.md
# paddle_sampler

Clock-domain front end for the analog paddle inputs. It synchronises the asynchronous `hpaddle`/`vpaddle` comparator lines into `clk` and filters them. It then timestamps the first rising edge of each line per frame against `vpos` and publishes both positions once per frame at the rising edge of `vsync`. Its outputs feed the player-position/display logic directly, replacing any capture clocked by the paddle lines themselves.

## Interface
- `WIDTH`, 16: width of `vpos` and of the position outputs.
- `MISS_VALUE`, all ones: value published for a paddle that showed no rising edge during the frame.
- `FILTER_LEN`, 4: consecutive high samples required to accept an edge; only used with `PADDLE_FILTER_EN`; legal range 1–15.
- `clk` in 1: system clock, the same clock as the hvsync generator.
- `reset` in 1: asynchronous, active-high reset.
- `hpaddle` in 1: horizontal paddle comparator, asynchronous to `clk`.
- `vpaddle` in 1: vertical paddle comparator, asynchronous to `clk`.
- `vsync` in 1: vertical sync, synchronous to `clk`, active high.
- `vpos` in WIDTH: current scanline from the hvsync generator.
- `paddle_x` out WIDTH: published horizontal paddle position.
- `paddle_y` out WIDTH: published vertical paddle position.
- `hmiss` out 1: set when the last published `paddle_x` is `MISS_VALUE` because no edge was seen.
- `vmiss` out 1: set when the last published `paddle_y` is `MISS_VALUE` because no edge was seen.
- `frame_valid` out 1: one-cycle pulse on the cycle the outputs update.

## Operation
- **Synchroniser.** Each paddle input passes through a 2-flop synchroniser, then a third register used for edge detection.
- **Edge.** An edge is synchronised-high this cycle and low the previous cycle, or the filtered equivalent (see Configuration).
- **Frame boundary.** A frame boundary is the `vsync` rising edge: `vsync` high and the registered `vsync` low.
- **Per-channel FSM**, two states:
  - ARMED: on an edge, capture `vpos` into `cap_*` and go to CAPTURED.
  - CAPTURED: ignore further edges until the next frame boundary.
- **On a frame boundary, per channel:**
  - CAPTURED: publish `cap_*`, clear `*miss`.
  - ARMED: publish `MISS_VALUE`, set `*miss`.
  - In both cases return to ARMED.
- **Edge and boundary in the same cycle.** The publish uses the pre-cycle state. The edge is captured into the new frame, so the FSM ends in CAPTURED holding this cycle's `vpos`.
- **Publish.** Both channels update on the same cycle. `frame_valid` pulses that cycle.
- **Level at reset release.** If a paddle input is already high when `reset` releases, no edge is generated until it goes low and high again.
- **Arithmetic.** `vpos` is stored verbatim; the block performs no arithmetic on it.

## Timing
- **Reset values:**
  - `paddle_x`, `paddle_y`: 0.
  - `hmiss`, `vmiss`, `frame_valid`: 0.
  - FSMs: ARMED.
  - Synchroniser and edge registers, registered `vsync`: 0.
- **Capture latency, no filter.** A paddle rise sampled at clock edge N is detected at edge N+2. The value captured is `vpos` as seen at edge N+2.
- **Publish latency.** The `vsync` rise sampled at edge M updates outputs and pulses `frame_valid` in the cycle following edge M, i.e. registered outputs.
- **Output stability.** Outputs hold their value between publishes.
- **Reset mid-frame.** Asserting `reset` mid-frame discards captures. The first publish after reset reflects only edges seen after release.
- **Repeated edges.** Glitches or repeated pulses within one frame never change the captured value.

## Configuration
- **`PADDLE_FILTER_EN` defined:** an edge is accepted only when the synchronised input has been high for `FILTER_LEN` consecutive cycles after being low.
  - The captured `vpos` is the value on the accepting cycle, adding `FILTER_LEN`−1 cycles of latency.
  - A high pulse shorter than `FILTER_LEN` is ignored.
  - The counter clears whenever the input is low, and on reset.
- **`PADDLE_FILTER_EN` undefined:** no counter is built; any single-cycle synchronised rise is an edge.

## Test plan
- **Normal capture.** Reset, release. Raise `hpaddle` while `vpos`=100 and `vpaddle` while `vpos`=200, then pulse `vsync`.
  - Expect `paddle_x`=102 and `paddle_y`=202, reflecting the 2-cycle latency with `vpos` stepping once per cycle in the bench.
  - Expect `frame_valid` high for exactly 1 cycle, and `hmiss`=`vmiss`=0.
- **Miss.** No `vpaddle` edge in a frame.
  - Expect `paddle_y`=16'hFFFF and `vmiss`=1.
  - Expect `paddle_x` to be updated normally.
- **Multiple edges.** `hpaddle` pulses at `vpos`=50 and again at `vpos`=80 in one frame → `paddle_x`=52.
- **Simultaneous edge and boundary.** A detected `hpaddle` edge coincides with the `vsync` rise (`vpos`=300).
  - The current publish is unaffected.
  - The next frame publishes `paddle_x`=300 even with no further edges.
- **Mid-frame reset.** Capture `hpaddle` at `vpos`=40, assert `reset`, release, then pulse `vsync` with no new edges.
  - Immediately after reset: all outputs 0.
  - After the publish: `paddle_x`=16'hFFFF and `hmiss`=1.
- **Filter** (with `PADDLE_FILTER_EN`, `FILTER_LEN`=4). A 2-cycle glitch at `vpos`=10, then a sustained rise at `vpos`=60 → `paddle_x`=65.
